// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encoding, instruction field layout and opcodes
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Instruction word layout
    localparam int REG_MSB  = 13;
    localparam int REG_LSB  = 12;
    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Opcodes shared with the execute stage
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// rtl/fetch_unit_pc_counter.sv - program counter with clear, load and modulo-PROG_LEN increment
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        force pc to RESET_PC (highest priority)
//   load         load load_addr (caller guarantees it is in range)
//   load_addr    jump target
//   inc          advance pc, wrapping PROG_LEN-1 -> RESET_PC
//   pc           current program counter
module pc_counter #(
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= START_PC;
        end else if (clear) begin
            pc <= START_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            // Wrap at the program length, not at 2^ADDR_W
            pc <= (pc == LAST_PC) ? START_PC : pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM access, IR and issue handshake
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin fetching at RESET_PC (honoured in IDLE and HALT)
//   stall         execute busy; holds the issued instruction
//   jump_en       PC load request, sampled only when an instruction is consumed
//   jump_addr     jump target
//   rom_oe        ROM output enable (FETCH only)
//   rom_addr      ROM address, equal to pc
//   rom_data      combinational ROM read data
//   instr_valid   instruction fields valid for execute
//   instr_reg     IR[13:12] register select
//   instr_code    IR[11:8] operation code
//   instr_data    IR[7:0] immediate
//   pc            address of the next fetch
//   halted        HALT state reached
//   jump_fault    one-cycle pulse after an out-of-range jump
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int         ADDR_W    = 5,
    parameter int         INSTR_W   = 16,
    parameter int         PROG_LEN  = 16,
    parameter int         RESET_PC  = 0,
    parameter logic [3:0] HALT_CODE = OP_HALT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               rom_oe,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    output logic [1:0]         instr_reg,
    output logic [3:0]         instr_code,
    output logic [7:0]         instr_data,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               jump_fault
);

    localparam logic [ADDR_W:0] PROG_LEN_X = (ADDR_W + 1)'(PROG_LEN);

    fetch_state_t        state;
    logic [INSTR_W-1:0]  ir;
    logic                consume;
    logic                jump_ok;
    logic                restart;
    logic                unused_ir_top;
    logic                unused_rom_top;

    assign consume = (state == S_ISSUE) && !stall;
    assign jump_ok = ({1'b0, jump_addr} < PROG_LEN_X);
    assign restart = start && ((state == S_IDLE) || (state == S_HALT));

    // A bad jump lands on RESET_PC through the same path as a restart
    pc_counter #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart || (consume && jump_en && !jump_ok)),
        .load      (consume && jump_en && jump_ok),
        .load_addr (jump_addr),
        .inc       (consume && !jump_en),
        .pc        (pc)
    );

    assign rom_addr   = pc;
    assign instr_reg  = ir[REG_MSB:REG_LSB];
    assign instr_code = ir[CODE_MSB:CODE_LSB];
    assign instr_data = ir[DATA_MSB:DATA_LSB];

    // Bits above the register field carry no meaning for fetch
    assign unused_ir_top  = ^ir[INSTR_W-1:REG_MSB+1];
    assign unused_rom_top = ^rom_data[INSTR_W-1:REG_MSB+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ir          <= '0;
            rom_oe      <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            jump_fault  <= 1'b0;
        end else begin
            jump_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_FETCH;
                        rom_oe <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir     <= rom_data;
                    rom_oe <= 1'b0;
                    // A HALT word is latched but never presented as valid
                    if (rom_data[CODE_MSB:CODE_LSB] == HALT_CODE) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state       <= S_ISSUE;
                        instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        state       <= S_FETCH;
                        instr_valid <= 1'b0;
                        rom_oe      <= 1'b1;
                        jump_fault  <= jump_en && !jump_ok;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        halted <= 1'b0;
                        rom_oe <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 16-cell program ROM.
- Owns the program counter and drives the ROM address and output enable.
- Captures the 16-bit instruction word into an instruction register and splits it into fields.
- Hands the fields to the execute stage over a valid/stall handshake; handles jumps, halt and PC wrap-around.

Parameters:
- ADDR_W, 5, width of PC / ROM address.
- INSTR_W, 16, instruction word width.
- PROG_LEN, 16, number of valid program cells; PC wraps at PROG_LEN-1.
- RESET_PC, 0, PC value after reset and on restart.
- HALT_CODE, 4'hF, instruction code that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from RESET_PC; sampled in IDLE and HALT.
- stall  in  1  execute busy; holds the issued instruction.
- jump_en  in  1  execute requests PC load; sampled only on consume.
- jump_addr  in  ADDR_W  jump target.
- rom_oe  out  1  ROM output enable.
- rom_addr  out  ADDR_W  ROM address (= pc).
- rom_data  in  INSTR_W  ROM read data, combinational from rom_addr/rom_oe.
- instr_valid  out  1  instruction fields valid for execute.
- instr_reg  out  2  IR[13:12], R1 R0 register select.
- instr_code  out  4  IR[11:8], operation code.
- instr_data  out  8  IR[7:0], immediate.
- pc  out  ADDR_W  address of the next fetch.
- halted  out  1  HALT state reached.
- jump_fault  out  1  one-cycle pulse on an out-of-range jump.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, IR=0.
  - rom_oe=0, rom_addr=RESET_PC, instr_valid=0, halted=0, jump_fault=0.
  - Deassertion takes effect at the next clk edge; reset mid-operation discards IR and any pending jump.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - rom_oe=0.
  - start=1 -> FETCH with pc=RESET_PC.
- FETCH:
  - rom_oe=1, rom_addr=pc.
  - At the clk edge IR<=rom_data.
  - If rom_data[11:8]==HALT_CODE -> HALT; else -> ISSUE.
  - rom_oe=0 in every state other than FETCH.
- ISSUE:
  - instr_valid=1; fields driven from IR and held stable while stall=1.
  - Consume occurs when stall=0; state -> FETCH.
  - On consume with jump_en=1 and jump_addr<PROG_LEN: pc<=jump_addr.
  - On consume with jump_en=1 and jump_addr>=PROG_LEN: pc<=RESET_PC, jump_fault=1 for one cycle.
  - On consume with jump_en=0: pc<=pc+1, or RESET_PC when pc==PROG_LEN-1 (wrap).
  - jump_en is ignored while stall=1.
- HALT:
  - halted=1, instr_valid=0, pc frozen at the HALT cell address.
  - The HALT instruction is never issued.
  - start=1 -> pc=RESET_PC, halted=0, -> FETCH.
- start in FETCH or ISSUE is ignored.
- Latency:
  - start at edge N -> FETCH in cycle N+1 -> instr_valid in cycle N+2.
  - Throughput without stall: 1 instruction per 2 cycles.
- Width rules:
  - pc increment is modulo PROG_LEN, never 2^ADDR_W.
  - Cells PROG_LEN..2^ADDR_W-1 are never addressed.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=0, FETCH=1, ISSUE=2, HALT=3).
  - Instruction field bit positions (REG 13:12, CODE 11:8, DATA 7:0).
  - HALT_CODE and the opcode list shared with execute.
- Natural sub-module: pc_counter (load / increment-with-wrap / reset-to-RESET_PC); FSM and IR stay in fetch_unit.

Test Plan:
- Reset, then start=1 with ROM cell0=16'h1203 -> two cycles later instr_valid=1, instr_reg=2'b01, instr_code=4'h2, instr_data=8'h03; pc=0 while issued, 1 after consume.
- Linear program cells 0..15 with no HALT, stall=0 -> addresses 0,1,...,15,0 fetched in order; pc wraps 15->0; one valid every 2 cycles.
- stall=1 for 5 cycles during ISSUE of cell3 -> instr fields unchanged, rom_oe=0, pc=3 throughout; release -> pc=4 next cycle.
- Consume with jump_en=1, jump_addr=9 -> next rom_addr=9; jump_addr=20 -> next rom_addr=0, jump_fault pulses once.
- Cell5=16'h0F00 -> halted=1 after fetch of cell5, instr_valid stays 0, pc=5; start=1 -> fetch restarts at 0, halted=0.
- rst_n low during ISSUE of cell7 -> outputs return to reset values immediately (async); after release, fetch resumes only on start.
